// File: rtl/insn_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps at most one word read
// outstanding to instruction memory and queues returned words for the core.
module insn_fetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] InsR,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
);
  localparam int               PTR_W      = $clog2(DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [31:0]      RESET_PC_W = RESET_PC & ~32'h3;

  // DRAIN: a redirect arrived while a read was in flight; the old request is
  // held until its ack, and that word is thrown away.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      drain_addr_q, drain_addr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_ack;
  logic [31:0]      data_q    [DEPTH];
  logic [31:0]      fifo_pc_q [DEPTH];
  logic             push;
  logic             pop;
  logic [31:0]      redirect_word;

  // Handshakes: mem_req stays high with a stable mem_addr until the one-cycle
  // mem_ack completes it; the head entry leaves on ins_valid && ins_ready,
  // except in a redirect cycle, where the whole FIFO is flushed instead.
  assign redirect_word = redirect_pc & ~32'h3;
  assign pop           = ins_valid & ins_ready & ~redirect_valid;
  assign count_ack     = count_q + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_word;
          state_d    = REQ;
        end else if (count_q < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_word;
          if (!mem_ack) begin
            state_d      = DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_ack < DEPTH_C) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (redirect_valid) fetch_pc_d = redirect_word;
        if (mem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = '0;
    rd_ptr_d = '0;
    count_d  = '0;
    if (!redirect_valid) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC_W;
      drain_addr_q <= RESET_PC_W;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q]    <= mem_rdata;
      fifo_pc_q[wr_ptr_q] <= fetch_pc_q;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
  assign ins_valid = (count_q != '0);
  assign InsR      = ins_valid ? data_q[rd_ptr_q] : 32'h0;
  assign ins_pc    = ins_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Bench for insn_fetch_ctrl: directed vector table, two scripted fetch
// sequences with a PC scoreboard, and a randomized run against a queue model.
module tb_insn_fetch_ctrl;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] InsR;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  insn_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .InsR(InsR), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  // instruction memory contents; word 0 is fe010113
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'hfe01_0113;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: apply inputs after a falling edge, return at the next falling edge
  task automatic step(input logic r, input logic a, input logic [31:0] d,
                      input logic rdy, input logic rv, input logic [31:0] rp);
    rst = r; mem_ack = a; mem_rdata = d; ins_ready = rdy;
    redirect_valid = rv; redirect_pc = rp;
    @(posedge clk);
    @(negedge clk);
  endtask

  // scoreboard of expected delivery PCs
  logic [31:0] exp_q[$];

  task automatic sb_check(input string name);
    logic [31:0] pc;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected delivery pc %h, nothing expected", name, ins_pc);
    end else begin
      pc = exp_q.pop_front();
      check32({name, " pc"}, ins_pc, pc);
      check32({name, " insr"}, InsR, mem_word(pc));
    end
  endtask

  // vector table
  typedef struct {
    logic        rst, ack, ready, redir;
    logic [31:0] rdata, rpc;
    logic        exp_req, chk_addr;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic rdy, logic rv,
                              logic [31:0] rp, logic er, logic ca, logic [31:0] ea,
                              logic ev, logic [31:0] ep);
    vec_t t;
    t.rst = r; t.ack = a; t.rdata = d; t.ready = rdy; t.redir = rv; t.rpc = rp;
    t.exp_req = er; t.chk_addr = ca; t.exp_addr = ea; t.exp_valid = ev; t.exp_pc = ep;
    return t;
  endfunction

  // queue-level reference model: FIFO contents, next fetch PC, in-flight read
  logic [63:0] m_fifo[$];
  logic        m_out;
  logic        m_discard;
  logic [31:0] m_out_addr;
  logic [31:0] m_next_pc;

  task automatic model_reset();
    m_fifo.delete();
    m_out = 1'b0; m_discard = 1'b0;
    m_out_addr = RESET_PC; m_next_pc = RESET_PC;
  endtask

  task automatic model_step(input logic r, input logic a, input logic [31:0] d,
                            input logic rdy, input logic rv, input logic [31:0] rp);
    int  sz;
    logic take;
    if (r) begin
      model_reset();
      return;
    end
    sz   = m_fifo.size();
    take = rdy && (sz > 0) && !rv;
    if (rv) m_fifo.delete();
    if (take) void'(m_fifo.pop_front());
    if (rv) m_next_pc = rp & ~32'h3;
    if (m_out) begin
      if (a) begin
        if (m_discard || rv) begin
          m_discard  = 1'b0;
          m_out_addr = m_next_pc;
        end else begin
          m_fifo.push_back({m_out_addr, d});
          m_next_pc = m_out_addr + 32'd4;
          if (m_fifo.size() < DEPTH) m_out_addr = m_next_pc;
          else m_out = 1'b0;
        end
      end else if (rv) begin
        m_discard = 1'b1;
      end
    end else if (rv || sz < DEPTH) begin
      m_out      = 1'b1;
      m_out_addr = m_next_pc;
    end
  endtask

  task automatic model_compare(input int cyc);
    logic [63:0] head;
    head = (m_fifo.size() > 0) ? m_fifo[0] : 64'h0;
    check1($sformatf("rnd%0d mem_req", cyc), mem_req, m_out);
    if (m_out) check32($sformatf("rnd%0d mem_addr", cyc), mem_addr, m_out_addr);
    check1($sformatf("rnd%0d ins_valid", cyc), ins_valid, m_fifo.size() > 0);
    check32($sformatf("rnd%0d insr", cyc), InsR, head[31:0]);
    check32($sformatf("rnd%0d ins_pc", cyc), ins_pc, head[63:32]);
  endtask

  initial begin
    logic        a;
    logic [31:0] d;
    logic        rdy;
    logic        rv;
    logic [31:0] rp;
    logic        r;
    int          waited;
    int          acks;
    int          bias;
    logic [31:0] exp_addr;
    logic        first;

    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; ins_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // directed vectors: inputs for one cycle, outputs expected after its edge
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'h0), 0, 0, 0, 1, 1, 32'h4, 1, 32'h0));
    vecs.push_back(mk(0, 1, mem_word(32'h4), 0, 0, 0, 1, 1, 32'h8, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8, 1, 32'h4));
    vecs.push_back(mk(0, 1, mem_word(32'h8), 1, 0, 0, 1, 1, 32'hc, 1, 32'h8));
    vecs.push_back(mk(0, 1, mem_word(32'hc), 0, 0, 0, 1, 1, 32'h10, 1, 32'h8));
    vecs.push_back(mk(0, 1, mem_word(32'h10), 0, 0, 0, 1, 1, 32'h14, 1, 32'h8));
    vecs.push_back(mk(0, 1, mem_word(32'h14), 0, 0, 0, 0, 0, 32'h0, 1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 1, 32'hc));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h18, 1, 32'hc));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h103, 1, 1, 32'h18, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h18, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'h18), 0, 0, 0, 1, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'h100), 0, 0, 0, 1, 1, 32'h104, 1, 32'h100));
    vecs.push_back(mk(0, 1, mem_word(32'h104), 1, 1, 32'h200, 1, 1, 32'h200, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'h200), 1, 0, 0, 1, 1, 32'h204, 1, 32'h200));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, 32'hdeadbeef, 0, 0, 0, 1, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'h0), 1, 0, 0, 1, 1, 32'h4, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h300, 1, 1, 32'h4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h400, 1, 1, 32'h4, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'h4), 0, 0, 0, 1, 1, 32'h400, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'h400), 1, 0, 0, 1, 1, 32'h404, 1, 32'h400));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h404, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'hffff_fffe, 1, 1, 32'h404, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'h404), 0, 0, 0, 1, 1, 32'hffff_fffc, 0, 0));
    vecs.push_back(mk(0, 1, mem_word(32'hffff_fffc), 0, 0, 0, 1, 1, 32'h0, 1, 32'hffff_fffc));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step(v.rst, v.ack, v.rdata, v.ready, v.redir, v.rpc);
      check1($sformatf("vec%0d mem_req", i), mem_req, v.exp_req);
      if (v.chk_addr) check32($sformatf("vec%0d mem_addr", i), mem_addr, v.exp_addr);
      check1($sformatf("vec%0d ins_valid", i), ins_valid, v.exp_valid);
      check32($sformatf("vec%0d insr", i), InsR, v.exp_valid ? mem_word(v.exp_pc) : 32'h0);
      check32($sformatf("vec%0d ins_pc", i), ins_pc, v.exp_valid ? v.exp_pc : 32'h0);
    end

    // sequence 1: acks one cycle after the request, core always ready
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    exp_q.delete();
    waited = 0; exp_addr = RESET_PC; first = 1'b1;
    for (int c = 0; c < 12; c++) begin
      a = 1'b0; d = '0;
      if (ins_valid) sb_check($sformatf("seq1 c%0d", c));
      if (mem_req) begin
        if (waited == 1) begin
          a = 1'b1; d = mem_word(mem_addr);
          check32($sformatf("seq1 c%0d mem_addr", c), mem_addr, exp_addr);
          exp_q.push_back(exp_addr);
          exp_addr += 32'd4;
          waited = 0;
        end else begin
          waited = 1;
        end
      end
      step(0, a, d, 1, 0, 0);
      if (a && first) begin
        check1("seq1 first valid", ins_valid, 1'b1);
        check32("seq1 first insr", InsR, 32'hfe01_0113);
        check32("seq1 first pc", ins_pc, 32'h0);
        first = 1'b0;
      end
    end

    // sequence 2: core stalled, zero-latency acks fill the FIFO, then drain
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    exp_q.delete();
    acks = 0; exp_addr = RESET_PC;
    for (int c = 0; c < 8; c++) begin
      a = mem_req;
      if (a) begin
        check32($sformatf("seq2 c%0d mem_addr", c), mem_addr, exp_addr);
        exp_q.push_back(exp_addr);
        exp_addr += 32'd4;
        acks++;
      end
      step(0, a, a ? mem_word(mem_addr) : 32'h0, 0, 0, 0);
    end
    check32("seq2 ack count", 32'(acks), 32'(DEPTH));
    check1("seq2 full mem_req", mem_req, 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (ins_valid) sb_check($sformatf("seq2 drain c%0d", c));
      step(0, 0, 0, 1, 0, 0);
    end
    check32("seq2 undelivered", 32'(exp_q.size()), 32'h0);
    check1("seq2 refetch mem_req", mem_req, 1'b1);
    check32("seq2 refetch mem_addr", mem_addr, 32'h10);

    // randomized run against the queue model
    step(1, 0, 0, 0, 0, 0);
    model_reset();
    bias = 2;
    for (int c = 0; c < 3000; c++) begin
      model_compare(c);
      if (c % 64 == 0) bias = $urandom_range(0, 4);
      r   = ($urandom_range(0, 299) == 0);
      a   = mem_req && ($urandom_range(0, 2) == 0);
      d   = $urandom;
      rdy = ($urandom_range(0, 3) < bias);
      rv  = ($urandom_range(0, 15) == 0);
      rp  = $urandom;
      model_step(r, a, d, rdy, rv, rp);
      step(r, a, d, rdy, rv, rp);
    end
    model_compare(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
